// File: rtl/debug_slave_scan_master.sv
// Fabric-side virtual-JTAG scan initiator: one command = IR load, DR shift, DR update.
// Optional ir_out capture is built when DEBUG_SLAVE_SCAN_IR_OUT_EN is defined.
module debug_slave_scan_master #(
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int unsigned CNT_W = (TCK_DIV > 2) ? $clog2(TCK_DIV) : 1;
  localparam int unsigned BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam int unsigned HALF  = TCK_DIV / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SHIFT, S_UDR, S_RTI, S_RSP
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q;
  logic [DR_WIDTH-1:0] sr_q, cap_q, rsp_dr_q, sr_shift;
  logic [IR_WIDTH-1:0] ir_in_q;
  logic                tck_q, tck_d, tdi_q;
  logic                uir_q, cdr_q, sdr_q, udr_q, rti_q;
  logic                cmd_ready_q, rsp_valid_q;
  logic                active, period_end, rise_pt;

  assign active     = (state_q != S_IDLE) && (state_q != S_RSP);
  assign period_end = (cnt_q == CNT_W'(TCK_DIV - 1));
  assign rise_pt    = (cnt_q == CNT_W'(HALF - 1));
  assign sr_shift   = sr_q >> 1;

  // Divider runs only during a scan; tck is suppressed from RTI onwards.
  always_comb begin
    cnt_d = '0;
    tck_d = 1'b0;
    if (active) begin
      cnt_d = period_end ? '0 : cnt_q + 1'b1;
    end
    if (state_q inside {S_UIR, S_CDR, S_SHIFT, S_UDR}) begin
      tck_d = (cnt_d >= CNT_W'(HALF));
    end
  end

`ifdef DEBUG_SLAVE_SCAN_IR_OUT_EN
  logic [IR_WIDTH-1:0] ir_cap_q, rsp_ir_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_cap_q     <= '0;
      rsp_ir_out_q <= '0;
    end else begin
      if (state_q == S_UIR && rise_pt) ir_cap_q <= vji_ir_out;
      if (state_q == S_RTI && period_end) rsp_ir_out_q <= ir_cap_q;
    end
  end

  assign rsp_ir_out = rsp_ir_out_q;
`else
  logic unused_ir_out;
  assign unused_ir_out = ^vji_ir_out;
  assign rsp_ir_out    = '0;
`endif

  // Scan sequencer; state strobes and tdi move only on tck falling edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      cap_q       <= '0;
      rsp_dr_q    <= '0;
      ir_in_q     <= '0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
      if (state_q == S_SHIFT && rise_pt) cap_q[bit_q] <= vji_tdo;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            ir_in_q     <= cmd_ir;
            sr_q        <= cmd_dr;
            cmd_ready_q <= 1'b0;
            uir_q       <= 1'b1;
            state_q     <= S_UIR;
          end
        end
        S_UIR: begin
          if (period_end) begin
            uir_q   <= 1'b0;
            cdr_q   <= 1'b1;
            state_q <= S_CDR;
          end
        end
        S_CDR: begin
          if (period_end) begin
            cdr_q   <= 1'b0;
            sdr_q   <= 1'b1;
            bit_q   <= '0;
            tdi_q   <= sr_q[0];
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (period_end) begin
            if (bit_q == BIT_W'(DR_WIDTH - 1)) begin
              sdr_q   <= 1'b0;
              udr_q   <= 1'b1;
              tdi_q   <= 1'b0;
              state_q <= S_UDR;
            end else begin
              sr_q  <= sr_shift;
              tdi_q <= sr_shift[0];
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        S_UDR: begin
          if (period_end) begin
            udr_q   <= 1'b0;
            rti_q   <= 1'b1;
            ir_in_q <= '0;
            state_q <= S_RTI;
          end
        end
        S_RTI: begin
          if (period_end) begin
            rti_q       <= 1'b0;
            rsp_dr_q    <= cap_q;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dr    = rsp_dr_q;
  assign vji_tck   = tck_q;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_in_q;
  assign vji_uir   = uir_q;
  assign vji_cdr   = cdr_q;
  assign vji_sdr   = sdr_q;
  assign vji_udr   = udr_q;
  assign vji_rti   = rti_q;

endmodule
